tx_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer sharing one serial TX unit among NUM_REQ

---
 rtl/tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one serial TX unit among NUM_REQ requesters.
// Optional transmit watchdog is enabled by defining TX_ARB_WATCHDOG_EN.
module tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 55,
    parameter int WD_CYCLES = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      err,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        XMIT   = 2'd2
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WD_CYCLES < 1 || WD_CYCLES > 256) begin : g_bad_cfg
        $error("tx_arbiter: NUM_REQ must be 2..8 and WD_CYCLES 1..256");
    end

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     win_q, win_d;
    logic [PTR_W-1:0]     next_ptr;
    logic                 found;
    logic [PTR_W-1:0]     pick;

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    assign next_ptr = PTR_W'((int'(win_q) + 1) % NUM_REQ);

`ifdef TX_ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(WD_CYCLES - 1);
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        tx_data_d = tx_data_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
`ifdef TX_ARB_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = LAUNCH;
                    gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    tx_data_d = req_data[int'(pick)*DATA_W +: DATA_W];
                    win_d     = pick;
                end
            end
            LAUNCH: begin
                state_d = XMIT;
`ifdef TX_ARB_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            XMIT: begin
                if (tx_ready) begin
                    // gnt_q is already the winner's one-hot, so it doubles as the done vector.
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
`ifdef TX_ARB_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    err_d    = 1'b1;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            tx_data_q <= '0;
            rr_ptr_q  <= '0;
            win_q     <= '0;
`ifdef TX_ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            tx_data_q <= tx_data_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
`ifdef TX_ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);
    assign tx_start = (state_q == LAUNCH);
`ifdef TX_ARB_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 55;
    localparam int WD = 80;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tx_ready = 1'b0;
    logic [N-1:0]      req = '0;
    logic [DW-1:0]     pdata [N];
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt, done;
    logic              busy, err, tx_start;
    logic [DW-1:0]     tx_data;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .WD_CYCLES(WD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_total = 0;
    int m_ptr = 0;
    int start_cnt = 0, multi_gnt = 0;

    always @(negedge clk) begin
        if (tx_start) start_cnt++;
        if (!$onehot0(gnt)) multi_gnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: winner is the first requester at or after the pointer, modulo N.
    function automatic int pick(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++)
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic logic [DW-1:0] rand_pkt();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic do_reset;
        rst = 1'b1; req = '0; tx_ready = 1'b0;
        tick;
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Called in the LAUNCH cycle; leaves the bench in the first XMIT cycle.
    task automatic launch_check(input int w, input logic [DW-1:0] ed);
        check("launch_gnt", gnt, 64'd1 << w);
        check("launch_start", tx_start, 1);
        check("launch_data", tx_data, ed);
        check("launch_busy", busy, 1);
        tick;
        check("start_one_cycle", tx_start, 0);
        check("xmit_gnt", gnt, 64'd1 << w);
    endtask

    // tx_ready arrives lat cycles after tx_start; leaves the bench in the done cycle.
    task automatic finish_xmit(input int w, input int lat, input logic [DW-1:0] ed);
        int stray;
        stray = 0;
        repeat (lat - 1) begin
            if (tx_start || done != '0 || err) stray++;
            tick;
        end
        check("xmit_quiet", stray, 0);
        check("data_held", tx_data, ed);
        check("gnt_held", gnt, 64'd1 << w);
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        check("done_pulse", done, 64'd1 << w);
        check("done_gnt_clr", gnt, 0);
        check("done_idle", busy, 0);
        check("done_no_err", err, 0);
        m_ptr = (w + 1) % N;
    endtask

    task automatic serve(input int lat, input bit mutate, output int w);
        logic [DW-1:0] ed;
        w  = pick(req, m_ptr);
        ed = pdata[w];
        tick;
        launch_check(w, ed);
        if (mutate) begin
            pdata[w] = rand_pkt();
            if ($urandom_range(0, 1) == 0) req[w] = 1'b0;
        end
        finish_xmit(w, lat, ed);
    endtask

    initial begin
        int w, w2, bad, s0;
        logic [DW-1:0] ed;
        foreach (pdata[i]) pdata[i] = '0;

        // Reset values
        repeat (2) tick;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        rst = 1'b0;
        m_ptr = 0;

        // Single packet on port 2, ready 62 cycles after start
        pdata[2] = 55'h0A5_A5A5_A5A5_A5A5;
        req = 4'b0100;
        serve(62, 1'b0, w);
        req[2] = 1'b0;
        tick;
        check("t1_done_clr", done, 0);
        check("t1_idle", busy, 0);

        // All four requesting, each dropped on its done
        do_reset;
        for (int i = 0; i < N; i++) pdata[i] = rand_pkt();
        s0 = start_cnt;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            serve(1 + int'($urandom_range(0, 5)), 1'b0, w);
            req[w] = 1'b0;
        end
        tick;
        check("t2_starts", start_cnt - s0, 4);
        check("t2_idle", busy, 0);

        // Ports 1 and 3 re-request immediately
        req = 4'b1010;
        pdata[1] = rand_pkt();
        pdata[3] = rand_pkt();
        for (int i = 0; i < 8; i++) begin
            serve(1 + int'($urandom_range(0, 4)), 1'b0, w);
            pdata[w] = rand_pkt();
        end
        req = '0;
        tick;

        // tx_ready in IDLE and in LAUNCH is ignored
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        check("t4_idle_done", done, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_gnt", gnt, 0);
        pdata[0] = rand_pkt();
        req = 4'b0001;
        w  = pick(req, m_ptr);
        ed = pdata[w];
        tick;
        check("t4_launch", tx_start, 1);
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        check("t4_launch_done", done, 0);
        check("t4_launch_gnt", gnt, 64'd1 << w);
        check("t4_launch_busy", busy, 1);
        finish_xmit(w, 5, ed);
        req[w] = 1'b0;
        tick;

        // Asynchronous reset during XMIT
        pdata[2] = rand_pkt();
        req = 4'b0100;
        w  = pick(req, m_ptr);
        ed = pdata[w];
        tick;
        launch_check(w, ed);
        repeat (19) tick;
        #1 rst = 1'b1;
        #1;
        check("t5_gnt", gnt, 0);
        check("t5_busy", busy, 0);
        check("t5_start", tx_start, 0);
        check("t5_done", done, 0);
        m_ptr = 0;
        req = 4'b0101;
        pdata[0] = rand_pkt();
        tick;
        rst = 1'b0;
        serve(3, 1'b0, w);
        check("t5_port0_first", w, 0);
        req[w] = 1'b0;
        serve(2, 1'b0, w);
        req[w] = 1'b0;
        tick;

        // Randomized traffic against the round-robin model
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!req[j] && $urandom_range(0, 2) == 0) begin
                    req[j]   = 1'b1;
                    pdata[j] = rand_pkt();
                end
            end
            if (req == '0) begin
                w = int'($urandom_range(0, N - 1));
                req[w]   = 1'b1;
                pdata[w] = rand_pkt();
            end
            serve(1 + int'($urandom_range(0, 11)), 1'b1, w);
            req[w] = 1'b0;
        end
        req = '0;
        tick;
        check("rand_idle", busy, 0);

        // Transmission that never completes
        pdata[0] = rand_pkt();
        pdata[1] = rand_pkt();
        req = 4'b0011;
        w  = pick(req, m_ptr);
        ed = pdata[w];
        tick;
        launch_check(w, ed);
        bad = 0;
`ifdef TX_ARB_WATCHDOG_EN
        repeat (WD - 1) begin
            if (err || done != '0 || !busy) bad++;
            tick;
        end
        if (err || done != '0 || !busy) bad++;
        check("t6_wait_quiet", bad, 0);
        tick;
        check("t6_err", err, 1);
        check("t6_no_done", done, 0);
        check("t6_gnt_clr", gnt, 0);
        check("t6_idle", busy, 0);
        m_ptr = (w + 1) % N;
        req[w] = 1'b0;
        w2 = pick(req, m_ptr);
        ed = pdata[w2];
        tick;
        check("t6_err_pulse", err, 0);
        launch_check(w2, ed);
        finish_xmit(w2, 3, ed);
        req = '0;
        tick;
`else
        repeat (WD + 20) begin
            if (err || done != '0 || !busy || gnt != (4'b0001 << w)) bad++;
            tick;
        end
        check("t6_stuck_xmit", bad, 0);
        check("t6_no_err", err, 0);
        check("t6_busy", busy, 1);
`endif

        check("gnt_onehot", multi_gnt, 0);
        if (n_pass + n_fail != n_total) $error("comparison bookkeeping inconsistent");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
